// File: rtl/uart_ctl_rx.sv
// rtl/uart_ctl_rx.sv - UART 8N1 receiver and one-byte command decoder feeding the frame controller
module uart_ctl_rx #(
    parameter int CLKS_PER_BIT = 35,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic clk_4M,
    input  logic rst,
    input  logic uart_rx,
    input  logic ctl_ready,
    output logic ctl_valid,
    output logic ctl_incr,
    output logic ctl_decr,
    output logic frame_err,
    output logic overrun,
    output logic rx_active
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    // Terminal counts: the counter restarts at 0 on every state change,
    // so a sample lands when it reaches N-1.
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic          stop_ok;
    logic          stop_bad;
    logic          cmd_incr;
    logic          cmd_decr;
    logic          cmd_hit;
    logic          xfer;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk_4M) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // Receive FSM state, timing counter, bit index and shift register.
    always_ff @(posedge clk_4M) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic: mid-bit sampling from the start edge, LSB first.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n     = '0;
                bit_idx_n = 3'd0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    // A start bit that is high again by mid-bit was a glitch.
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        stop_ok = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_n  = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it reports only one framing error.
                cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign cmd_incr  = stop_ok && ((shift == 8'h2B) || (shift == 8'h6E));
    assign cmd_decr  = stop_ok && ((shift == 8'h2D) || (shift == 8'h70));
    assign cmd_hit   = cmd_incr || cmd_decr;
    assign xfer      = ctl_valid && ctl_ready;
    assign rx_active = (state != S_IDLE);

    // One-entry command buffer plus the error pulses; a new command may
    // replace one that is leaving on the same edge.
    always_ff @(posedge clk_4M) begin
        if (rst) begin
            ctl_valid <= 1'b0;
            ctl_incr  <= 1'b0;
            ctl_decr  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (cmd_hit) begin
                if (!ctl_valid || xfer) begin
                    ctl_valid <= 1'b1;
                    ctl_incr  <= cmd_incr;
                    ctl_decr  <= cmd_decr;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                ctl_valid <= 1'b0;
                ctl_incr  <= 1'b0;
                ctl_decr  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_ctl_rx.sv
// tb/tb_uart_ctl_rx.sv - directed self-checking bench for uart_ctl_rx
`timescale 1ns/1ps
module tb_uart_ctl_rx;

    localparam int CPB = 35;

    logic clk_4M    = 1'b0;
    logic rst       = 1'b1;
    logic uart_rx   = 1'b1;
    logic ctl_ready = 1'b0;
    logic ctl_valid;
    logic ctl_incr;
    logic ctl_decr;
    logic frame_err;
    logic overrun;
    logic rx_active;

    int checks   = 0;
    int failures = 0;

    int cyc          = 0;
    int valid_cycles = 0;
    int incr_cycles  = 0;
    int decr_cycles  = 0;
    int ferr_cycles  = 0;
    int ovr_cycles   = 0;
    int bad_onehot   = 0;
    int last_rise    = -1;
    int start_cyc    = 0;
    logic prev_v     = 1'b0;
    logic [5:0] snap = 6'h3F;

    uart_ctl_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_4M    (clk_4M),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .ctl_ready (ctl_ready),
        .ctl_valid (ctl_valid),
        .ctl_incr  (ctl_incr),
        .ctl_decr  (ctl_decr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_active (rx_active)
    );

    always #125 clk_4M = ~clk_4M;

    always @(posedge clk_4M) cyc <= cyc + 1;

    // Output activity counters, sampled mid-cycle.
    always @(negedge clk_4M) begin
        if (ctl_valid) valid_cycles++;
        if (ctl_valid && ctl_incr) incr_cycles++;
        if (ctl_valid && ctl_decr) decr_cycles++;
        if (frame_err) ferr_cycles++;
        if (overrun) ovr_cycles++;
        if (!ctl_valid && (ctl_incr || ctl_decr)) bad_onehot++;
        if (ctl_valid && (ctl_incr == ctl_decr)) bad_onehot++;
        if (ctl_valid && !prev_v) last_rise = cyc;
        prev_v = ctl_valid;
    end

    task automatic tick();
        @(posedge clk_4M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one 10-bit frame, one bit per CPB cycles; optionally pulses
    // ctl_ready or rst for a single edge at a given cycle of the frame.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int rdy_at, input int rst_at);
        logic [9:0] frame;
        frame     = {stop, b, 1'b0};
        start_cyc = cyc;
        for (int c = 0; c < 10 * CPB; c++) begin
            uart_rx = frame[c / CPB];
            if (c == rdy_at) ctl_ready = 1'b1;
            if (rdy_at >= 0 && c == rdy_at + 1) ctl_ready = 1'b0;
            if (c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                rst  = 1'b0;
                snap = {ctl_valid, ctl_incr, ctl_decr, frame_err, overrun, rx_active};
            end
            tick();
        end
    endtask

    int v0, i0, d0, f0, o0, bad;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outs", 32'({ctl_valid, ctl_incr, ctl_decr, frame_err, overrun, rx_active}), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // '+' with ready low: latency, hold, single-cycle handshake
        ctl_ready = 1'b0;
        send_byte(8'h2B, 1'b1, -1, -1);
        chk("t1_latency", 32'(last_rise), 32'(start_cyc + 335));
        chk("t1_cmd", 32'({ctl_valid, ctl_incr, ctl_decr}), 32'b110);
        bad = 0;
        repeat (200) begin
            tick();
            if ({ctl_valid, ctl_incr, ctl_decr} !== 3'b110) bad++;
        end
        chk("t1_hold", 32'(bad), 32'd0);
        ctl_ready = 1'b1;
        tick();
        ctl_ready = 1'b0;
        chk("t1_after_xfer", 32'({ctl_valid, ctl_incr, ctl_decr}), 32'd0);

        // 'p' then 'A' with ready high
        ctl_ready = 1'b1;
        v0 = valid_cycles; i0 = incr_cycles; d0 = decr_cycles;
        send_byte(8'h70, 1'b1, -1, -1);
        send_byte(8'h41, 1'b1, -1, -1);
        repeat (20) tick();
        chk("t2_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        chk("t2_decr_cycles", 32'(decr_cycles - d0), 32'd1);
        chk("t2_incr_cycles", 32'(incr_cycles - i0), 32'd0);

        // 10-cycle low glitch
        v0 = valid_cycles; f0 = ferr_cycles;
        uart_rx = 1'b0;
        repeat (5) tick();
        chk("t3_active_in_start", 32'(rx_active), 32'd1);
        repeat (5) tick();
        uart_rx = 1'b1;
        repeat (30) tick();
        chk("t3_active_after", 32'(rx_active), 32'd0);
        chk("t3_no_valid", 32'(valid_cycles - v0), 32'd0);
        chk("t3_no_ferr", 32'(ferr_cycles - f0), 32'd0);

        // '-' with low stop bit, then break held for 500 cycles
        v0 = valid_cycles; f0 = ferr_cycles;
        send_byte(8'h2D, 1'b0, -1, -1);
        bad = 0;
        repeat (500) begin
            tick();
            if (rx_active !== 1'b1) bad++;
        end
        chk("t4_ferr_once", 32'(ferr_cycles - f0), 32'd1);
        chk("t4_no_valid", 32'(valid_cycles - v0), 32'd0);
        chk("t4_active_in_break", 32'(bad), 32'd0);
        uart_rx = 1'b1;
        repeat (5) tick();
        chk("t4_idle_after_break", 32'(rx_active), 32'd0);
        i0 = incr_cycles;
        send_byte(8'h2B, 1'b1, -1, -1);
        repeat (5) tick();
        chk("t4_recover_incr", 32'(incr_cycles - i0), 32'd1);

        // Back-to-back with ready low: second command overruns
        ctl_ready = 1'b0;
        o0 = ovr_cycles;
        send_byte(8'h2B, 1'b1, -1, -1);
        send_byte(8'h2D, 1'b1, -1, -1);
        repeat (5) tick();
        chk("t5_overrun_once", 32'(ovr_cycles - o0), 32'd1);
        chk("t5_keeps_incr", 32'({ctl_valid, ctl_incr, ctl_decr}), 32'b110);
        ctl_ready = 1'b1;
        tick();
        ctl_ready = 1'b0;
        chk("t5_drained", 32'(ctl_valid), 32'd0);

        // Transfer on the same edge as the next decode
        o0 = ovr_cycles;
        send_byte(8'h2B, 1'b1, -1, -1);
        send_byte(8'h2D, 1'b1, 334, -1);
        chk("t5_swap_decr", 32'({ctl_valid, ctl_incr, ctl_decr}), 32'b101);
        chk("t5_swap_no_overrun", 32'(ovr_cycles - o0), 32'd0);

        // Reset mid-byte with a command buffered
        send_byte(8'h2B, 1'b1, -1, 190);
        chk("t6_reset_outs", 32'(snap), 32'd0);
        repeat (300) tick();
        chk("t6_no_cmd", 32'(ctl_valid), 32'd0);
        chk("t6_idle", 32'(rx_active), 32'd0);
        ctl_ready = 1'b1;
        i0 = incr_cycles;
        send_byte(8'h6E, 1'b1, -1, -1);
        repeat (5) tick();
        chk("t6_next_incr", 32'(incr_cycles - i0), 32'd1);

        chk("onehot_rule", 32'(bad_onehot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
